tlb_array: RTL and testbench

Parametrised TLB storage array, successor of the fixed 32-entry, four-port LUT-RAM TLB store in the CPU. It holds DEPTH translation entries (payload plus header), serves registered instruction/data lookups and a TLBR read port, and performs TLBWI/TLBWR writes. It also generates the CP0 Random index and manages per-entry valid bits, including a multi-cycle flush that runs automatically after reset.

---
 rtl/tlb_pkg.sv | 14 +
 rtl/tlb_mem_bank.sv | 27 ++
 rtl/tlb_array.sv | 140 ++++++++++++++
 tb/tb_tlb_array.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared constants and types for the TLB storage array.
// Default geometry matches the legacy 32-entry store.
package tlb_pkg;

  localparam int TLB_DEPTH = 32;
  localparam int TLB_EW    = 50;
  localparam int TLB_HW    = 44;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } tlbState_t;

endpackage

// File: rtl/tlb_mem_bank.sv
// Distributed-RAM style bank: one synchronous write port,
// NR asynchronous read ports, no reset on the storage.
module tlb_mem_bank #(
  parameter int W  = 8,
  parameter int D  = 32,
  parameter int NR = 1,
  localparam int AW = $clog2(D)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          wrAddr,
  input  logic [W-1:0]           wrData,
  input  logic [NR-1:0][AW-1:0]  rdAddr,
  output logic [NR-1:0][W-1:0]   rdData
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
  end

  for (genvar g = 0; g < NR; g++) begin : gRd
    assign rdData[g] = mem[rdAddr[g]];
  end

endmodule

// File: rtl/tlb_array.sv
// TLB entry store: registered lookups, TLBR/TLBWI/TLBWR,
// CP0 Random generation and a multi-cycle valid-bit flush.
import tlb_pkg::*;

module tlb_array #(
  parameter int DEPTH = TLB_DEPTH,
  parameter int EW    = TLB_EW,
  parameter int HW    = TLB_HW,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] ia_idx,
  output logic [EW-1:0] ia_entry,
  output logic          ia_vld,
  input  logic [IW-1:0] db_idx,
  output logic [EW-1:0] db_entry,
  output logic          db_vld,
  input  logic [IW-1:0] rd_idx,
  output logic [EW-1:0] rd_entry,
  output logic [HW-1:0] rd_hdr,
  input  logic          we,
  input  logic          wr_rand,
  input  logic [IW-1:0] wr_idx,
  input  logic [EW-1:0] wr_entry,
  input  logic [HW-1:0] wr_hdr,
  input  logic [IW-1:0] wired,
  output logic [IW-1:0] random,
  input  logic          flush_req,
  output logic          busy
);

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  tlbState_t        state, stateNxt;
  logic [IW-1:0]    fcnt, fcntNxt;
  logic [DEPTH-1:0] valid, validNxt;
  logic [IW-1:0]    randNxt;
  logic [IW-1:0]    wrTgt;
  logic             doWr;
  logic             iaVldQ, dbVldQ;
  logic             iaHit, dbHit, rdHit;

  logic [2:0][EW-1:0] payRd;
  logic [0:0][HW-1:0] hdrRd;

  assign busy  = (state == ST_FLUSH);
  assign wrTgt = wr_rand ? random : wr_idx;
  assign doWr  = we & ~busy;

  assign iaHit = doWr && (ia_idx == wrTgt);
  assign dbHit = doWr && (db_idx == wrTgt);
  assign rdHit = doWr && (rd_idx == wrTgt);

  tlb_mem_bank #(
    .W(EW), .D(DEPTH), .NR(3)
  ) uPay (
    .clk    (clk),
    .we     (doWr),
    .wrAddr (wrTgt),
    .wrData (wr_entry),
    .rdAddr ({rd_idx, db_idx, ia_idx}),
    .rdData (payRd)
  );

  tlb_mem_bank #(
    .W(HW), .D(DEPTH), .NR(1)
  ) uHdr (
    .clk    (clk),
    .we     (doWr),
    .wrAddr (wrTgt),
    .wrData (wr_hdr),
    .rdAddr (rd_idx),
    .rdData (hdrRd)
  );

  always_comb begin
    stateNxt = state;
    fcntNxt  = fcnt;
    validNxt = valid;
    if (doWr) validNxt[wrTgt] = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (flush_req) begin
          stateNxt = ST_FLUSH;
          fcntNxt  = '0;
        end
      end
      ST_FLUSH: begin
        validNxt[fcnt] = 1'b0;
        fcntNxt = fcnt + 1'b1;
        if (fcnt == LAST) stateNxt = ST_IDLE;
      end
    endcase
  end

  // A Wired value at the top index pins Random there.
  always_comb begin
    randNxt = random - 1'b1;
    if (wired == LAST || random <= wired) randNxt = LAST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_FLUSH;
      fcnt   <= '0;
      valid  <= '0;
      random <= LAST;
    end else begin
      state  <= stateNxt;
      fcnt   <= fcntNxt;
      valid  <= validNxt;
      random <= randNxt;
    end
  end

  // Sampling the next valid vector gives write-first vld
  // and sees the entry being cleared on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ia_entry <= '0;
      db_entry <= '0;
      rd_entry <= '0;
      rd_hdr   <= '0;
      iaVldQ   <= 1'b0;
      dbVldQ   <= 1'b0;
    end else begin
      ia_entry <= iaHit ? wr_entry : payRd[0];
      db_entry <= dbHit ? wr_entry : payRd[1];
      rd_entry <= rdHit ? wr_entry : payRd[2];
      rd_hdr   <= rdHit ? wr_hdr   : hdrRd[0];
      iaVldQ   <= validNxt[ia_idx];
      dbVldQ   <= validNxt[db_idx];
    end
  end

  assign ia_vld = iaVldQ & ~busy;
  assign db_vld = dbVldQ & ~busy;

endmodule

// File: tb/tb_tlb_array.sv
// Scoreboard bench for tlb_array: stimulus queues expected
// outputs per cycle, a monitor compares after each edge.
module tb_tlb_array;

  localparam int DEPTH = 32;
  localparam int EW    = 50;
  localparam int HW    = 44;
  localparam int IW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] ia_idx, db_idx, rd_idx, wr_idx, wired;
  logic [EW-1:0] ia_entry, db_entry, rd_entry, wr_entry;
  logic [HW-1:0] rd_hdr, wr_hdr;
  logic          ia_vld, db_vld, we, wr_rand, flush_req, busy;
  logic [IW-1:0] random;

  always #5 clk = ~clk;

  tlb_array #(.DEPTH(DEPTH), .EW(EW), .HW(HW)) dut (
    .clk(clk), .rst(rst),
    .ia_idx(ia_idx), .ia_entry(ia_entry), .ia_vld(ia_vld),
    .db_idx(db_idx), .db_entry(db_entry), .db_vld(db_vld),
    .rd_idx(rd_idx), .rd_entry(rd_entry), .rd_hdr(rd_hdr),
    .we(we), .wr_rand(wr_rand), .wr_idx(wr_idx),
    .wr_entry(wr_entry), .wr_hdr(wr_hdr),
    .wired(wired), .random(random),
    .flush_req(flush_req), .busy(busy)
  );

  typedef enum int {
    K_IAE, K_IAV, K_DBE, K_DBV, K_RDE, K_RDH, K_RAND, K_BUSY
  } kind_t;

  typedef struct {
    int          tag;
    kind_t       kind;
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;
  logic [IW-1:0] expRand = 5'd31;

  localparam logic [EW-1:0] E5 = 50'h3_FFFF_0000_1234;
  localparam logic [HW-1:0] H5 = 44'h123_4567_89AB;
  localparam logic [EW-1:0] E9 = 50'h0_1234_5678_9ABC;
  localparam logic [HW-1:0] H9 = 44'hABC_DEF0_1234;
  localparam logic [EW-1:0] E8 = 50'h2_5555_AAAA_0008;
  localparam logic [HW-1:0] H8 = 44'h888_0000_8888;
  localparam logic [EW-1:0] E3 = 50'h1_3333_3333_3333;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(kind_t k);
    case (k)
      K_IAE:   return 64'(ia_entry);
      K_IAV:   return 64'(ia_vld);
      K_DBE:   return 64'(db_entry);
      K_DBV:   return 64'(db_vld);
      K_RDE:   return 64'(rd_entry);
      K_RDH:   return 64'(rd_hdr);
      K_RAND:  return 64'(random);
      K_BUSY:  return 64'(busy);
      default: return 64'hDEAD;
    endcase
  endfunction

  // Monitor: pop everything due for this cycle.
  exp_t        e;
  logic [63:0] got;
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      got = actual(e.kind);
      nCmp++;
      if (e.tag != cyc || got !== e.val) begin
        nBad++;
        $display("FAIL %s: got %h want %h (cyc %0d due %0d)",
                 e.name, got, e.val, cyc, e.tag);
      end
    end
  end

  task automatic chk(kind_t k, string n, logic [63:0] v);
    exp_t x;
    x.tag  = cyc + 1;
    x.kind = k;
    x.name = n;
    x.val  = v;
    sb.push_back(x);
  endtask

  function automatic logic [IW-1:0] nextRand();
    if (rst) return 5'd31;
    if (wired == 5'd31 || expRand <= wired) return 5'd31;
    return 5'(expRand - 5'd1);
  endfunction

  task automatic tick();
    expRand = nextRand();
    @(negedge clk);
  endtask

  function automatic logic [EW-1:0] fillVal(int i);
    return 50'h1_0000_0000_0000 | 50'(i * 7 + 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ia_idx = '0; db_idx = '0; rd_idx = '0;
    we = 1'b0; wr_rand = 1'b0; wr_idx = '0;
    wr_entry = '0; wr_hdr = '0; wired = '0;
    flush_req = 1'b0;
    @(negedge clk);

    // Reset state
    chk(K_BUSY, "rst_busy", 64'd1);
    chk(K_RAND, "rst_random", 64'd31);
    chk(K_IAE, "rst_ia_entry", 64'd0);
    chk(K_DBE, "rst_db_entry", 64'd0);
    chk(K_RDE, "rst_rd_entry", 64'd0);
    chk(K_RDH, "rst_rd_hdr", 64'd0);
    chk(K_IAV, "rst_ia_vld", 64'd0);
    chk(K_DBV, "rst_db_vld", 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Post-reset flush: busy for 32 cycles; Random 31..0, 31, 30
    for (int k = 1; k <= 33; k++) begin
      ia_idx = 5'(k % 32);
      chk(K_BUSY, "init_busy", 64'(k <= 31));
      chk(K_RAND, "init_random",
          64'((k <= 31) ? 31 - k : (k == 32 ? 31 : 30)));
      chk(K_IAV, "init_ia_vld", 64'd0);
      tick();
    end

    // TLBWI idx 5
    we = 1'b1; wr_idx = 5'd5; wr_entry = E5; wr_hdr = H5;
    ia_idx = 5'd0;
    tick();
    we = 1'b0;
    ia_idx = 5'd5; db_idx = 5'd6;
    chk(K_IAE, "wi5_ia_entry", 64'(E5));
    chk(K_IAV, "wi5_ia_vld", 64'd1);
    chk(K_DBV, "wi6_db_vld", 64'd0);
    tick();
    db_idx = 5'd5;
    chk(K_DBE, "wi5_db_entry", 64'(E5));
    chk(K_DBV, "wi5_db_vld", 64'd1);
    tick();

    // Same-edge write and lookup at idx 9
    we = 1'b1; wr_idx = 5'd9; wr_entry = E9; wr_hdr = H9;
    ia_idx = 5'd9; rd_idx = 5'd9;
    chk(K_IAE, "byp_ia_entry", 64'(E9));
    chk(K_IAV, "byp_ia_vld", 64'd1);
    chk(K_RDE, "byp_rd_entry", 64'(E9));
    chk(K_RDH, "byp_rd_hdr", 64'(H9));
    tick();
    we = 1'b0;
    rd_idx = 5'd5;
    chk(K_RDE, "tlbr5_entry", 64'(E5));
    chk(K_RDH, "tlbr5_hdr", 64'(H5));
    tick();

    // wired=8: Random walks down to 8, then TLBWR
    wired = 5'd8;
    for (int n = 0; n < 64 && expRand != 5'd8; n++) begin
      chk(K_RAND, "wired8_random", 64'(nextRand()));
      tick();
    end
    we = 1'b1; wr_rand = 1'b1; wr_idx = 5'd1;
    wr_entry = E8; wr_hdr = H8;
    ia_idx = 5'd8; rd_idx = 5'd8;
    chk(K_RAND, "wr_random_wrap", 64'd31);
    chk(K_IAE, "wr_ia_entry", 64'(E8));
    chk(K_IAV, "wr_ia_vld", 64'd1);
    chk(K_RDH, "wr_rd_hdr", 64'(H8));
    tick();
    we = 1'b0; wr_rand = 1'b0;
    db_idx = 5'd8; ia_idx = 5'd1;
    chk(K_DBE, "wr8_db_entry", 64'(E8));
    chk(K_DBV, "wr8_db_vld", 64'd1);
    chk(K_IAV, "wr_not_idx1", 64'd0);
    chk(K_RAND, "wired8_after", 64'd30);
    tick();
    wired = 5'd31;
    for (int n = 0; n < 3; n++) begin
      chk(K_RAND, "wired31_hold", 64'd31);
      tick();
    end
    wired = 5'd0;

    // Fill all entries
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; wr_idx = 5'(i);
      wr_entry = fillVal(i); wr_hdr = 44'(i + 100);
      tick();
    end
    we = 1'b0;
    ia_idx = 5'd31; db_idx = 5'd0; rd_idx = 5'd17;
    chk(K_IAE, "fill_ia31", 64'(fillVal(31)));
    chk(K_IAV, "fill_ia31_vld", 64'd1);
    chk(K_DBE, "fill_db0", 64'(fillVal(0)));
    chk(K_DBV, "fill_db0_vld", 64'd1);
    chk(K_RDH, "fill_rd17_hdr", 64'd117);
    tick();

    // Flush with a same-cycle write to idx 3
    flush_req = 1'b1;
    we = 1'b1; wr_idx = 5'd3; wr_entry = E3;
    ia_idx = 5'd3;
    chk(K_BUSY, "flush_busy0", 64'd1);
    chk(K_IAV, "flush_ia_vld0", 64'd0);
    tick();
    for (int k = 1; k <= 31; k++) begin
      we = (k == 5);
      wr_idx = 5'd2;
      flush_req = (k == 10);
      ia_idx = 5'(k);
      chk(K_BUSY, "flush_busy", 64'd1);
      chk(K_IAV, "flush_ia_vld", 64'd0);
      tick();
    end
    we = 1'b0; flush_req = 1'b0;
    chk(K_BUSY, "flush_done", 64'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      ia_idx = 5'(i); db_idx = 5'(31 - i);
      chk(K_IAV, "post_flush_ia_vld", 64'd0);
      chk(K_DBV, "post_flush_db_vld", 64'd0);
      tick();
    end

    // Reset in the middle of a flush restarts it
    flush_req = 1'b1;
    chk(K_BUSY, "f2_busy", 64'd1);
    tick();
    flush_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    chk(K_BUSY, "midrst_busy", 64'd1);
    chk(K_RAND, "midrst_random", 64'd31);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      chk(K_BUSY, "restart_busy", 64'(k <= 31));
      tick();
    end

    repeat (3) tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending want 0",
               sb.size());
      nCmp += sb.size();
      nBad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
